// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encodings, handshake FSM states
// and the opcode legality helper.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_ASR = 4'd8,
    OP_MUL = 4'd9,
    OP_CMP = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    OUT_HOLD = 2'd2
  } state_e;

  localparam logic [3:0] MUL_OPC = OP_MUL;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// The first bit is consumed on the start edge, so the product is ready WIDTH-1 edges later.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               done_reg;

  // Upper half accumulates the partial sum; lower half holds the unconsumed multiplier bits.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_reg  <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (start) begin
      prod_reg  <= step({{WIDTH{1'b0}}, b}, a);
      mcand_reg <= a;
      cnt_reg   <= CW'(WIDTH - 1);
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else if (busy_reg) begin
      prod_reg <= step(prod_reg, mcand_reg);
      cnt_reg  <= cnt_reg - 1'b1;
      if (cnt_reg == CW'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = prod_reg;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops load the output bank on
// the accept edge; MUL runs on the iterative multiplier and loads when it completes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             overflow_reg;
  logic             negative_reg;
  logic             err_reg;

  logic                accept;
  logic                out_drain_ok;
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_product;

  logic [SHW-1:0]      amt;
  logic [WIDTH:0]      sum_w;
  logic [WIDTH:0]      diff_w;
  logic [WIDTH:0]      shl_w;
  logic [WIDTH:0]      shr_w;
  logic signed [WIDTH:0] asr_w;
  logic                add_ovf;
  logic                sub_ovf;

  logic [WIDTH-1:0]    alu_res;
  logic [WIDTH-1:0]    flag_src;
  logic                alu_c;
  logic                alu_v;
  logic                alu_err;

  assign out_drain_ok = !out_valid_reg || out_ready;
  assign in_ready     = rst_n && (state_reg == IDLE) && out_drain_ok;
  assign accept       = in_valid && in_ready;
  assign mul_start    = accept && (opcode == MUL_OPC);

  // Shifts run one bit wider so the last bit shifted out lands in a fixed position.
  assign amt     = b[SHW-1:0];
  assign sum_w   = {1'b0, a} + {1'b0, b};
  assign diff_w  = {1'b0, a} - {1'b0, b};
  assign shl_w   = {1'b0, a} << amt;
  assign shr_w   = {a, 1'b0} >> amt;
  assign asr_w   = $signed({a, 1'b0}) >>> amt;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_err  = 1'b0;
    flag_src = '0;
    case (opcode)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        alu_c   = asr_w[0];
      end
      OP_CMP: begin
        alu_res = a;
        alu_c   = diff_w[WIDTH];
        alu_v   = sub_ovf;
      end
      OP_MUL: alu_res = '0;
      default: alu_err = !is_legal_op(opcode);
    endcase
    // CMP reports zero/negative of a-b while passing a through as the result.
    flag_src = (opcode == OP_CMP) ? diff_w[WIDTH-1:0] : alu_res;
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      negative_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mul_start) begin
            state_reg     <= MUL_BUSY;
            out_valid_reg <= 1'b0;
          end else if (accept) begin
            out_valid_reg <= 1'b1;
            result_reg    <= alu_res;
            result_hi_reg <= '0;
            zero_reg      <= (flag_src == '0);
            carry_reg     <= alu_c;
            overflow_reg  <= alu_v;
            negative_reg  <= flag_src[WIDTH-1];
            err_reg       <= alu_err;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MUL_BUSY: begin
          // Completion waits until any earlier result has been taken.
          if (mul_done && !mul_busy && out_drain_ok) begin
            out_valid_reg <= 1'b1;
            result_reg    <= mul_product[WIDTH-1:0];
            result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
            zero_reg      <= (mul_product == '0);
            carry_reg     <= 1'b0;
            overflow_reg  <= |mul_product[2*WIDTH-1:WIDTH];
            negative_reg  <= mul_product[WIDTH-1];
            err_reg       <= 1'b0;
            state_reg     <= out_ready ? IDLE : OUT_HOLD;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        OUT_HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;
  assign negative  = negative_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: table vectors and random ops through a scoreboard, plus
// hand-written MUL, back-pressure, reset and 16-bit sequences.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic       z, c, v, n, e;
  } exp_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       x;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic       zero, carry, overflow, negative, err;
  logic [7:0] a_s, b_s, result, result_hi;
  logic [3:0] opcode;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic        zero16, carry16, overflow16, negative16, err16;
  logic [15:0] a16, b16, result16, result_hi16;
  logic [3:0]  opcode16;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_s), .b(b_s), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .overflow(overflow), .negative(negative), .err(err)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .opcode(opcode16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .result_hi(result_hi16), .zero(zero16), .carry(carry16),
    .overflow(overflow16), .negative(negative16), .err(err16)
  );

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  exp_t got, want;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                              input logic [7:0] res, input logic [4:0] f);
    vec_t v;
    v.op = op; v.a = av; v.b = bv;
    v.x.res = res; v.x.hi = 8'h00;
    {v.x.z, v.x.c, v.x.v, v.x.n, v.x.e} = f;
    return v;
  endfunction

  // Reference model for the single-cycle ops at WIDTH=8, written with integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    int ua, ub, sa, sb2, amt, r;
    logic [7:0] fl;
    e = '0;
    ua = int'(av); ub = int'(bv);
    sa = int'($signed(av)); sb2 = int'($signed(bv));
    amt = int'(bv[2:0]); r = 0;
    case (op)
      4'd0: begin
        r = ua + ub; e.res = r[7:0]; e.c = (r > 255);
        e.v = (sa + sb2 > 127) || (sa + sb2 < -128);
      end
      4'd1, 4'd10: begin
        r = ua - ub; e.res = (op == 4'd10) ? av : r[7:0]; e.c = (ua < ub);
        e.v = (sa - sb2 > 127) || (sa - sb2 < -128);
      end
      4'd2: e.res = av & bv;
      4'd3: e.res = av | bv;
      4'd4: e.res = av ^ bv;
      4'd5: e.res = ~av;
      4'd6: begin
        e.res = 8'(ua << amt);
        e.c = (amt != 0) && (((ua >> (8 - amt)) & 1) != 0);
      end
      4'd7: begin
        e.res = 8'(ua >> amt);
        e.c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
      4'd8: begin
        r = sa >>> amt; e.res = r[7:0];
        e.c = (amt != 0) && (((sa >>> (amt - 1)) & 1) != 0);
      end
      default: begin
        e.z = 1'b1; e.e = 1'b1;
        return e;
      end
    endcase
    fl = (op == 4'd10) ? 8'(ua - ub) : e.res;
    e.z = (fl == 8'h00);
    e.n = fl[7];
    return e;
  endfunction

  task automatic send(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                      input exp_t e, output int waits);
    bit ok;
    ok = 1'b0; waits = 0;
    opcode = op; a_s = av; b_s = bv; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (ok) sb.push_back(e);
    else begin
      total_cnt++;
      $display("FAIL send_timeout: op %h never accepted", op);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: one line per completed result.
  always @(negedge clk) begin
    if (!rst_n) sb.delete();
    else if (out_valid && out_ready) begin
      got = {result, result_hi, zero, carry, overflow, negative, err};
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_out: got %h expected none", got);
      end else begin
        want = sb.pop_front();
        chk("scoreboard", 64'(got), 64'(want));
        $display("txn res=%h hi=%h zcvne=%b", result, result_hi, {zero, carry, overflow, negative, err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, total_w, cyc, seen;
    logic [3:0] rop;

    tbl[0]  = mk(4'd0,  8'hFF, 8'h01, 8'h00, 5'b11000);
    tbl[1]  = mk(4'd1,  8'h80, 8'h01, 8'h7F, 5'b00100);
    tbl[2]  = mk(4'd10, 8'h03, 8'h05, 8'h03, 5'b01010);
    tbl[3]  = mk(4'd0,  8'h7F, 8'h01, 8'h80, 5'b00110);
    tbl[4]  = mk(4'd6,  8'h81, 8'h01, 8'h02, 5'b01000);
    tbl[5]  = mk(4'd7,  8'h81, 8'h01, 8'h40, 5'b01000);
    tbl[6]  = mk(4'd8,  8'h81, 8'h03, 8'hF0, 5'b00010);
    tbl[7]  = mk(4'd6,  8'h5A, 8'h00, 8'h5A, 5'b00000);
    tbl[8]  = mk(4'd5,  8'h0F, 8'h00, 8'hF0, 5'b00010);
    tbl[9]  = mk(4'hC,  8'h12, 8'h34, 8'h00, 5'b10001);
    tbl[10] = mk(4'd7,  8'hC0, 8'h07, 8'h01, 5'b01000);
    tbl[11] = mk(4'd3,  8'h00, 8'h00, 8'h00, 5'b10000);
    tbl[12] = mk(4'd1,  8'h05, 8'h05, 8'h00, 5'b10000);
    tbl[13] = mk(4'd10, 8'h80, 8'h01, 8'h80, 5'b00100);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = 4'd0; a_s = 8'h00; b_s = 8'h00;
    in_valid16 = 1'b0; out_ready16 = 1'b1; opcode16 = 4'd0; a16 = 16'h0; b16 = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_outputs", 64'({result, result_hi, zero, carry, overflow, negative, err}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Table vectors, back to back
    for (int i = 0; i < 14; i++) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].x, w);
    repeat (3) @(posedge clk); #1;

    // MUL FF*FF: busy 8 cycles, result in cycle 9
    send(MUL_OPC, 8'hFF, 8'hFF, exp_t'({8'h01, 8'hFE, 5'b00100}), w);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy_c%0d", k), 64'({in_ready, out_valid}), 64'(0));
    end
    @(negedge clk);
    chk("mul_valid_c9", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    send(MUL_OPC, 8'h00, 8'h07, exp_t'({8'h00, 8'h00, 5'b10000}), w);
    repeat (12) @(posedge clk); #1;

    // Back-pressure hold, then simultaneous pop and push
    out_ready = 1'b0;
    send(4'd2, 8'hF0, 8'h3C, exp_t'({8'h30, 8'h00, 5'b00000}), w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid_ready", 64'({out_valid, in_ready}), 64'(2'b10));
      chk("hold_result", 64'(result), 64'(8'h30));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd4, 8'hAA, 8'hFF, exp_t'({8'h55, 8'h00, 5'b00000}), w);
    chk("popush_no_stall", 64'(w), 64'(0));
    @(negedge clk);
    chk("popush_next", 64'({out_valid, result}), 64'({1'b1, 8'h55}));
    repeat (2) @(posedge clk); #1;

    // Random single-cycle stream
    total_w = 0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      rop = 4'($urandom_range(0, 10));
      if (rop == MUL_OPC) rop = 4'hF;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      send(rop, ra, rb, model(rop, ra, rb), w);
      total_w += w;
    end
    chk("stream_throughput", 64'(total_w), 64'(0));
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a MUL
    send(MUL_OPC, 8'hFF, 8'hFF, exp_t'({8'h01, 8'hFE, 5'b00100}), w);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("midrst_outputs", 64'({out_valid, result, result_hi, zero, carry, overflow, negative, err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 64'(in_ready), 64'(1));
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_mul_discarded", 64'(seen), 64'(0));
    @(posedge clk); #1;

    // WIDTH=16: ADD FFFF+1
    opcode16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!in_ready16 && cyc < 50);
    chk("w16_add_accept", 64'(in_ready16), 64'(1));
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(negedge clk);
    chk("w16_add", 64'({out_valid16, result16, result_hi16, zero16, carry16, overflow16, negative16, err16}),
        64'({1'b1, 16'h0000, 16'h0000, 5'b11000}));
    @(posedge clk); #1;

    // WIDTH=16: MUL FFFF*FFFF, result in cycle 17
    opcode16 = MUL_OPC; a16 = 16'hFFFF; b16 = 16'hFFFF; in_valid16 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!in_ready16 && cyc < 50);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid16 && cyc < 40);
    chk("w16_mul_latency", 64'(cyc), 64'(17));
    chk("w16_mul", 64'({result16, result_hi16, zero16, carry16, overflow16, negative16, err16}),
        64'({16'h0001, 16'hFFFE, 5'b00100}));
    @(posedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
